uart_fifo: RTL
==============

UART_FIFO -- requirements
Module: uart_fifo

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 8, meaning the width of each stored word (matches MAX_UART_DATA_W).
REQ-002 The block SHALL provide parameter DEPTH, default 16, meaning the number of storage entries; it shall be a power of two and at least 2.
REQ-003 The block SHALL provide parameter ADDR_W, default 4, meaning the pointer width, equal to $clog2(DEPTH).
REQ-004 The block SHALL provide parameter AF_THRESH, default 12, meaning the level at or above which almost_full_o asserts.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port clr_i, input, 1 bit: synchronous flush.
REQ-008 The block SHALL have port push_i, input, 1 bit: write request (driven by the controller's rx_fifo_push_o or by the host).
REQ-009 The block SHALL have port data_i, input, DATA_W bits: write data.
REQ-010 The block SHALL have port pop_i, input, 1 bit: read/consume request (driven by the controller's tx_fifo_pop_o or by the host).
REQ-011 The block SHALL have port data_o, output, DATA_W bits: head-of-queue word.
REQ-012 The block SHALL have ports empty_o, full_o and almost_full_o, each output, 1 bit: status flags.
REQ-013 The block SHALL have port level_o, output, ADDR_W+1 bits: current occupancy, 0..DEPTH.
REQ-014 The block SHALL have ports overflow_o and underflow_o, each output, 1 bit: sticky error flags.

Function
REQ-015 Read semantics SHALL be first-word-fall-through: while empty_o=0, data_o equals the oldest stored word with no pop required.
REQ-016 While empty_o=1, data_o SHALL be all zeros.
REQ-017 A push with full_o=0 SHALL write data_i at the write pointer, advance the write pointer and increment level_o by 1 in the next cycle.
REQ-018 A pop with empty_o=0 SHALL advance the read pointer; data_o SHALL show the next word, or zero if the FIFO is now empty, in the next cycle.
REQ-019 Pointers SHALL wrap modulo DEPTH; wrap SHALL NOT corrupt level_o or the flags.
REQ-020 Simultaneous push and pop with 0<level<DEPTH SHALL accept both and leave level_o unchanged.
REQ-021 Simultaneous push and pop when full SHALL accept both: the pop removes the head, the push stores data_i, and level stays DEPTH.
REQ-022 Simultaneous push and pop when empty SHALL accept the push, ignore the pop and set underflow_o; level becomes 1.
REQ-023 A push when full without a pop SHALL be dropped, leave storage unchanged, and set overflow_o.
REQ-024 A pop when empty SHALL be ignored and set underflow_o.
REQ-025 empty_o SHALL be (level_o==0), full_o SHALL be (level_o==DEPTH), and almost_full_o SHALL be (level_o>=AF_THRESH); all are registered or derived from registered level with no combinational path from push_i/pop_i.
REQ-026 overflow_o and underflow_o SHALL remain set until clr_i or reset.
REQ-027 clr_i SHALL take priority over push_i/pop_i in the same cycle: pointers, level and sticky flags go to 0 next cycle, and stored data is not required to be erased.
REQ-028 Storage SHALL be a DEPTH x DATA_W register array with no reset on the array itself.

Reset
REQ-029 While rst_ni=0, the following SHALL hold asynchronously: pointers=0, level_o=0, empty_o=1, full_o=0, almost_full_o=0, overflow_o=0, underflow_o=0, data_o=0.
REQ-030 Reset asserted mid-operation SHALL discard all queued words; after reset deassertion the FIFO SHALL behave as empty on the first rising edge.

Verification
REQ-031 Reset with the FIFO holding 5 words, then release -> empty_o=1, level_o=0, data_o=0, flags 0.
REQ-032 Push 0x11,0x22,0x33 on consecutive cycles, then pop 3 times -> data_o sequence 0x11,0x22,0x33, then 0x00 with empty_o=1; level_o steps 1,2,3,2,1,0.
REQ-033 Fill 16 words (0x00..0x0F), push 0xAA -> full_o=1, overflow_o=1, 0xAA dropped; then push 0xBB with pop in the same cycle -> level stays 16 and 0xBB is read out last.
REQ-034 Pop when empty, and separately push 0x5A with pop when empty -> underflow_o=1; in the second case level_o=1 and data_o=0x5A.
REQ-035 Run 40 push/pop cycles through DEPTH=16 -> pointer wrap verified against a scoreboard; almost_full_o toggles exactly at level 12.
REQ-036 Assert clr_i together with push_i while level=7 and both sticky flags set -> next cycle level_o=0, empty_o=1, flags 0, and the pushed word is not stored.

Source files
------------

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO for UART byte buffering, with occupancy level,
// almost-full threshold and sticky overflow/underflow error flags.
module uart_fifo #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic [ADDR_W:0]   level_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W+1)'(AF_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              push_ok, pop_ok, mem_we;

    // Flags depend only on the registered level, never on push_i/pop_i.
    assign empty_o       = (level_q == '0);
    assign full_o        = (level_q == FULL_LVL);
    assign almost_full_o = (level_q >= AF_LVL);
    assign level_o       = level_q;
    assign overflow_o    = ovf_q;
    assign underflow_o   = udf_q;
    assign data_o        = empty_o ? '0 : mem[rd_ptr_q];

    always_comb begin
        // A full FIFO still accepts a push when a pop frees the head slot.
        push_ok  = push_i && (!full_o || pop_i);
        pop_ok   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q | (push_i && !push_ok);
        udf_d    = udf_q | (pop_i && empty_o);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (ADDR_W+1)'(1);
            2'b01:   level_d = level_q - (ADDR_W+1)'(1);
            default: level_d = level_q;
        endcase
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end
        mem_we = push_ok && !clr_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage carries no reset; emptiness is tracked solely by level_q.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

endmodule
